// File: rtl/player_rect_ctl_pkg.sv
// Shared types and constants for the player rectangle controller.
// Holds the vertical motion state encoding and the screen geometry.
package player_rect_ctl_pkg;

   typedef enum logic [1:0] {
      GROUND = 2'd0,
      RISE   = 2'd1,
      FALL   = 2'd2
   } jump_state_t;

   localparam int SCREEN_W = 1024;
   localparam int SCREEN_H = 768;
   localparam int COORD_W  = 11;
   localparam int VEL_W    = 6;

   // Falling speed grows until it pins at the largest 6-bit magnitude.
   function automatic logic [VEL_W-1:0] vel_sat_add(input logic [VEL_W-1:0] a,
                                                    input logic [VEL_W-1:0] b);
      logic [VEL_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[VEL_W] ? {VEL_W{1'b1}} : s[VEL_W-1:0];
   endfunction

endpackage

// File: rtl/player_rect_ctl_rect_hit.sv
// Registered point-in-rectangle test for the pixel path (1 clock latency).
// Sums are widened to 12 bits so the right/bottom edges never wrap.
module rect_hit
   import player_rect_ctl_pkg::*;
#(
   parameter int RECT_W = 64,
   parameter int RECT_H = 96
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [COORD_W-1:0] i_hcount,
   input  logic [COORD_W-1:0] i_vcount,
   input  logic [COORD_W-1:0] i_x,
   input  logic [COORD_W-1:0] i_y,
   output logic               o_hit
);

   logic [COORD_W:0] w_h;
   logic [COORD_W:0] w_v;
   logic [COORD_W:0] w_x;
   logic [COORD_W:0] w_y;
   logic [COORD_W:0] w_x_end;
   logic [COORD_W:0] w_y_end;
   logic             w_hit;
   logic             r_hit;

   assign w_h     = {1'b0, i_hcount};
   assign w_v     = {1'b0, i_vcount};
   assign w_x     = {1'b0, i_x};
   assign w_y     = {1'b0, i_y};
   assign w_x_end = w_x + (COORD_W+1)'(RECT_W);
   assign w_y_end = w_y + (COORD_W+1)'(RECT_H);

   assign w_hit = (w_h >= w_x) && (w_h < w_x_end) &&
                  (w_v >= w_y) && (w_v < w_y_end);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit <= 1'b0;
      end else begin
         r_hit <= w_hit;
      end
   end

   assign o_hit = r_hit;

endmodule

// File: rtl/player_rect_ctl.sv
// Player rectangle: per-frame walk and jump/gravity motion, plus registered
// per-pixel coverage and colour aligned with draw_bg's one-cycle-delayed counters.
module player_rect_ctl
   import player_rect_ctl_pkg::*;
#(
   parameter int          RECT_W     = 64,
   parameter int          RECT_H     = 96,
   parameter logic [11:0] RECT_COLOR = 12'hF80,
   parameter int          SCREEN_W   = 1024,
   parameter int          X_INIT     = 100,
   parameter int          GROUND_Y   = 600,
   parameter int          H_STEP     = 4,
   parameter int          JUMP_V0    = 20,
   parameter int          GRAVITY    = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        vsync_in,
   input  logic        move_left,
   input  logic        move_right,
   input  logic        jump,
   output logic        rectangle_on,
   output logic [11:0] rgb_rectangle,
   output logic [10:0] rect_x,
   output logic [10:0] rect_y,
   output logic        airborne
);

   localparam logic signed [11:0] H_STEP_S = 12'(H_STEP);
   localparam logic signed [11:0] X_MAX_S  = 12'(SCREEN_W - RECT_W);
   localparam logic [10:0]        X_RST    = 11'(X_INIT);
   localparam logic [10:0]        Y_GND    = 11'(GROUND_Y);
   localparam logic [11:0]        Y_GND_12 = 12'(GROUND_Y);
   localparam logic [5:0]         V0       = 6'(JUMP_V0);
   localparam logic [5:0]         GRAV     = 6'(GRAVITY);

   logic               r_vsync_d;
   logic               w_tick;
   logic [10:0]        r_x;
   logic [10:0]        r_y;
   logic [5:0]         r_vel;
   jump_state_t        r_state;
   logic               r_airborne;
   logic [11:0]        r_rgb;

   logic [10:0]        w_x_nxt;
   logic [10:0]        w_y_nxt;
   logic [5:0]         w_vel_nxt;
   jump_state_t        w_state_nxt;

   logic signed [11:0] w_x_s;
   logic signed [11:0] w_x_dec;
   logic signed [11:0] w_x_inc;
   logic [10:0]        w_vel_ext;
   logic [5:0]         w_vel_fall;
   logic [11:0]        w_y_fall;

   // Frame tick: single-cycle pulse on the rising edge of vsync.
   assign w_tick = vsync_in & ~r_vsync_d;

   assign w_x_s   = signed'({1'b0, r_x});
   assign w_x_dec = w_x_s - H_STEP_S;
   assign w_x_inc = w_x_s + H_STEP_S;

   always_comb begin
      w_x_nxt = r_x;
      if (w_tick) begin
         if (move_left && !move_right) begin
            w_x_nxt = (w_x_dec < 12'sd0) ? 11'd0 : w_x_dec[10:0];
         end else if (move_right && !move_left) begin
            w_x_nxt = (w_x_inc > X_MAX_S) ? X_MAX_S[10:0] : w_x_inc[10:0];
         end
      end
   end

   assign w_vel_ext  = {5'b0, r_vel};
   assign w_vel_fall = vel_sat_add(r_vel, GRAV);
   assign w_y_fall   = {1'b0, r_y} + {6'b0, w_vel_fall};

   always_comb begin
      w_state_nxt = r_state;
      w_y_nxt     = r_y;
      w_vel_nxt   = r_vel;
      if (w_tick) begin
         case (r_state)
            GROUND: begin
               if (jump) begin
                  w_state_nxt = RISE;
                  w_vel_nxt   = V0;
               end
            end
            RISE: begin
               // Rising faster than the remaining headroom hits the ceiling.
               if (w_vel_ext > r_y) begin
                  w_y_nxt     = 11'd0;
                  w_vel_nxt   = 6'd0;
                  w_state_nxt = FALL;
               end else begin
                  w_y_nxt = r_y - w_vel_ext;
                  if (r_vel <= GRAV) begin
                     w_vel_nxt   = 6'd0;
                     w_state_nxt = FALL;
                  end else begin
                     w_vel_nxt = r_vel - GRAV;
                  end
               end
            end
            FALL: begin
               if (w_y_fall >= Y_GND_12) begin
                  w_y_nxt     = Y_GND;
                  w_vel_nxt   = 6'd0;
                  w_state_nxt = GROUND;
               end else begin
                  w_y_nxt   = w_y_fall[10:0];
                  w_vel_nxt = w_vel_fall;
               end
            end
            default: begin
               w_state_nxt = GROUND;
               w_y_nxt     = Y_GND;
               w_vel_nxt   = 6'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vsync_d  <= 1'b0;
         r_x        <= X_RST;
         r_y        <= Y_GND;
         r_vel      <= 6'd0;
         r_state    <= GROUND;
         r_airborne <= 1'b0;
         r_rgb      <= 12'h000;
      end else begin
         r_vsync_d  <= vsync_in;
         r_x        <= w_x_nxt;
         r_y        <= w_y_nxt;
         r_vel      <= w_vel_nxt;
         r_state    <= w_state_nxt;
         r_airborne <= (w_state_nxt != GROUND);
         r_rgb      <= RECT_COLOR;
      end
   end

   // Coverage uses the position held before this cycle's update.
   rect_hit #(
      .RECT_W (RECT_W),
      .RECT_H (RECT_H)
   ) u_rect_hit (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_hcount (hcount_in),
      .i_vcount (vcount_in),
      .i_x      (r_x),
      .i_y      (r_y),
      .o_hit    (rectangle_on)
   );

   assign rgb_rectangle = r_rgb;
   assign rect_x        = r_x;
   assign rect_y        = r_y;
   assign airborne      = r_airborne;

endmodule

// File: tb/tb_player_rect_ctl.sv
// Bench for player_rect_ctl: a default instance and a low-ground instance (ceiling case)
// driven by the same stimulus and checked every cycle against a signed-velocity motion model.
module tb_player_rect_ctl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] hc, vc;
   logic        vs, ml, mr, jp;

   logic        on0, on1, air0, air1;
   logic [11:0] rgb0, rgb1;
   logic [10:0] x0, x1, y0, y1;

   int total = 0;
   int bad   = 0;

   // model: position, signed vertical speed (positive = upward), airborne flag
   int          mx[2], my[2], mvy[2], gy[2];
   bit          mair[2], mon[2];
   int          mrgb[2];
   bit          mvsp;

   always #5 clk = ~clk;

   player_rect_ctl dut0 (
      .clk(clk), .rst_n(rst_n), .hcount_in(hc), .vcount_in(vc), .vsync_in(vs),
      .move_left(ml), .move_right(mr), .jump(jp),
      .rectangle_on(on0), .rgb_rectangle(rgb0), .rect_x(x0), .rect_y(y0), .airborne(air0)
   );

   player_rect_ctl #(.GROUND_Y(10)) dut1 (
      .clk(clk), .rst_n(rst_n), .hcount_in(hc), .vcount_in(vc), .vsync_in(vs),
      .move_left(ml), .move_right(mr), .jump(jp),
      .rectangle_on(on1), .rgb_rectangle(rgb1), .rect_x(x1), .rect_y(y1), .airborne(air1)
   );

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      gy[0] = 600;
      gy[1] = 10;
      for (int i = 0; i < 2; i++) begin
         mx[i] = 100; my[i] = gy[i]; mvy[i] = 0;
         mair[i] = 0; mon[i] = 0; mrgb[i] = 0;
      end
      mvsp = 0;
   endtask

   // Advance the model by one clock using the inputs about to be sampled.
   task automatic model_step();
      bit tick;
      tick = vs && !mvsp;
      for (int i = 0; i < 2; i++) begin
         mon[i]  = (hc >= mx[i]) && (hc < mx[i] + 64) && (vc >= my[i]) && (vc < my[i] + 96);
         mrgb[i] = 'hF80;
         if (tick) begin
            if (ml && !mr)      mx[i] = (mx[i] - 4 < 0) ? 0 : mx[i] - 4;
            else if (mr && !ml) mx[i] = (mx[i] + 4 > 960) ? 960 : mx[i] + 4;
            if (!mair[i]) begin
               if (jp) begin mair[i] = 1; mvy[i] = 20; end
            end else if (mvy[i] > 0) begin
               if (mvy[i] > my[i]) begin my[i] = 0; mvy[i] = 0; end
               else begin my[i] -= mvy[i]; mvy[i] -= 1; end
            end else begin
               mvy[i] = (mvy[i] - 1 < -63) ? -63 : mvy[i] - 1;
               if (my[i] - mvy[i] >= gy[i]) begin my[i] = gy[i]; mvy[i] = 0; mair[i] = 0; end
               else my[i] -= mvy[i];
            end
         end
      end
      mvsp = vs;
   endtask

   task automatic compare_all();
      chk("x0", x0, mx[0]);     chk("y0", y0, my[0]);
      chk("air0", air0, mair[0]); chk("on0", on0, mon[0]); chk("rgb0", rgb0, mrgb[0]);
      chk("x1", x1, mx[1]);     chk("y1", y1, my[1]);
      chk("air1", air1, mair[1]); chk("on1", on1, mon[1]); chk("rgb1", rgb1, mrgb[1]);
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   // One frame: tick cycle with the given buttons, then two quiet cycles with random buttons.
   task automatic frame(input bit l, input bit r, input bit j);
      vs = 1; ml = l; mr = r; jp = j;
      cyc();
      vs = 0;
      for (int k = 0; k < 2; k++) begin
         ml = 1'($urandom); mr = 1'($urandom); jp = 1'($urandom);
         hc = 11'($urandom_range(0, 1100)); vc = 11'($urandom_range(0, 760));
         cyc();
      end
   endtask

   initial begin
      int t;
      rst_n = 0; hc = 0; vc = 0; vs = 0; ml = 0; mr = 0; jp = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      chk("rst_x", x0, 100); chk("rst_y", y0, 600); chk("rst_on", on0, 0); chk("rst_rgb", rgb0, 0);
      rst_n = 1;

      // pixel timing around the corner and right edge
      hc = 100; vc = 600; cyc(); chk("pix_corner", on0, 1); chk("pix_rgb", rgb0, 'hF80);
      hc = 164; cyc(); chk("pix_right_out", on0, 0);
      hc = 99;  cyc(); chk("pix_left_out", on0, 0);
      hc = 163; vc = 695; cyc(); chk("pix_br_in", on0, 1);
      vc = 696; cyc(); chk("pix_bottom_out", on0, 0);

      // jump arc and ceiling on the low-ground instance
      frame(0, 0, 1);
      chk("arc_t1", y0, 600); chk("arc_air", air0, 1);
      frame(0, 0, 0);
      chk("arc_t2", y0, 580); chk("ceil_y", y1, 0); chk("ceil_air", air1, 1);
      frame(0, 0, 0);
      chk("arc_t3", y0, 561);
      repeat (18) frame(0, 0, 0);
      chk("arc_apex", y0, 390); chk("arc_apex_air", air0, 1); chk("ceil_landed", y1, 10);
      repeat (19) frame(0, 0, 0);
      chk("arc_fall19", y0, 580);
      frame(0, 0, 0);
      chk("arc_land", y0, 600); chk("arc_land_air", air0, 0);
      frame(0, 0, 0);
      chk("arc_rest", y0, 600);

      // walk clamps
      repeat (10) frame(0, 1, 0);
      chk("walk_10", x0, 140);
      repeat (290) frame(0, 1, 0);
      chk("walk_clamp_r", x0, 960);
      repeat (3) frame(1, 1, 0);
      chk("walk_both", x0, 960);
      repeat (300) frame(1, 0, 0);
      chk("walk_clamp_l", x0, 0);

      // reset in mid-jump
      frame(0, 1, 1);
      frame(0, 0, 0);
      #2 rst_n = 0;
      #1;
      model_reset();
      compare_all();
      chk("midrst_y", y0, 600); chk("midrst_air", air0, 0); chk("midrst_x", x0, 100);
      @(posedge clk);
      #1;
      compare_all();
      rst_n = 1;
      frame(0, 0, 0);
      chk("post_rst_air", air0, 0);

      // randomized traffic, pixels kept near the default rectangle
      for (int n = 0; n < 6000; n++) begin
         vs = ($urandom_range(0, 5) == 0);
         ml = ($urandom_range(0, 2) == 0);
         mr = ($urandom_range(0, 2) == 0);
         jp = 1'($urandom);
         t = mx[0] + int'($urandom_range(0, 84)) - 10;
         hc = 11'((t < 0) ? 0 : t);
         t = my[0] + int'($urandom_range(0, 116)) - 10;
         vc = 11'((t < 0) ? 0 : t);
         if (n % 1500 == 1499) begin
            rst_n = 0;
            #1;
            model_reset();
            compare_all();
            @(posedge clk);
            #1;
            rst_n = 1;
         end else begin
            cyc();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
